writeback_unit: RTL and testbench
=================================

# writeback_unit

Writer end of the register-file write port: produces `W_rd_addr`, `W_rd` and the GPR write enable consumed by the decode stage's register file. It selects and formats the Write-back-stage result (ALU, load data with sign/zero extension, PC+4) and merges results from a long-latency unit (mul/div) through a small FIFO that drains into free write slots. It exports a pending-destination mask and a starvation stall request to the hazard unit.

## Interface
- `FIFO_DEPTH`, 2: long-latency result buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 4: cycles the FIFO head may wait before requesting a stall
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `W_valid`  in  1  Write-back stage holds a real instruction
- `W_gpr_wen_in`  in  1  instruction writes rd
- `W_rd_addr_in`  in  5  destination register
- `W_result_src`  in  2  `RES_ALU`, `RES_LOAD`, `RES_PC4`
- `W_alu_result`  in  32  ALU result; also load address, bits [1:0] = byte offset
- `W_mem_rdata`  in  32  raw aligned data-memory word
- `W_pc_plus4`  in  32  link value
- `W_funct3`  in  3  load size/sign (LB, LH, LW, LBU, LHU)
- `L_valid`  in  1  long-latency result offered
- `L_ready`  out  1  FIFO accepts
- `L_rd_addr`  in  5  long-latency destination
- `L_data`  in  32  long-latency result
- `W_rd_addr`  out  5  register-file write address
- `W_rd`  out  32  register-file write data
- `W_gpr_wen`  out  1  register-file write enable
- `pend_mask`  out  32  bit r set while any FIFO entry targets xr
- `W_stall_req`  out  1  starvation request to hazard unit

## Operation
- Pipeline write `pw = W_valid & W_gpr_wen_in & (W_rd_addr_in != 0)`.
- Result mux: ALU → `W_alu_result`; PC4 → `W_pc_plus4`; LOAD → `load_extend` output.
- Load: LB/LBU pick byte `off[1:0]`; LH/LHU pick halfword `off[1]` (off[0] ignored); LW ignores offset; LB/LH sign-extend, LBU/LHU zero-extend; undefined funct3 → full word.
- Priority: if `pw`, the pipeline owns the port; otherwise the FIFO head (if non-empty) is written and popped. Never both.
- L entries with `L_rd_addr == 0` are accepted and dropped (no push).
- `L_ready = (count < FIFO_DEPTH)`; independent of same-cycle pop (no comb path from W inputs).
- Push and pop in the same cycle: both take effect, count unchanged.
- Age counter: cleared on pop or when FIFO empty; increments each cycle the head waits, saturating at `STARVE_LIMIT`.
- `W_stall_req = (age == STARVE_LIMIT)`; hazard unit guarantees a bubble (`W_valid=0`) in W within one cycle; head drains in that bubble.
- `pend_mask`: OR of one-hot rd over valid entries; the hazard unit blocks issue of any instruction that reads or writes a masked register (no WAW/RAW ordering inside this block).
- Reset mid-operation: FIFO flushed, in-flight L results are lost; pipeline flush is the hazard unit's concern.

## Timing
- Write outputs are combinational from W inputs and FIFO head; the register file writes at the next `clk` edge.
- L result accepted at edge t is writable no earlier than cycle t+1 (no input-to-port bypass).
- While `reset` is low: `W_gpr_wen=0`, `W_rd_addr=0`, `W_rd=0`, `L_ready=0`, `pend_mask=0`, `W_stall_req=0`, count=0, age=0, pointers=0.
- First cycle after release: `L_ready=1`.
- Pointers wrap modulo `FIFO_DEPTH`.

## Structure
- `riscv_pkg`: `result_src_t` enum (`RES_ALU`, `RES_LOAD`, `RES_PC4`), load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
- Sub-module `load_extend` (combinational: funct3, offset, word → 32-bit value); FIFO, age counter and arbitration stay in `writeback_unit`.

## Test plan
- LB, off=3, rdata=0x80FF_1234, rd=x5 → `W_rd=0xFFFF_FF80`, `W_rd_addr=5`, `W_gpr_wen=1`; LHU off=2 same word → `0x0000_80FF`.
- `pw` to x0 → `W_gpr_wen=0`; L result to x0 → `L_ready` stays 1, `pend_mask` unchanged, nothing written.
- L pushes x7=0xDEAD_BEEF while `pw` busy for 2 cycles → `pend_mask[7]=1`, written in first cycle with `W_valid=0`, `pend_mask[7]` clears after that edge.
- Two L pushes with continuous `pw` → `L_ready=0` after second; head waits 4 cycles → `W_stall_req=1`; bubble → head written, `W_stall_req=0`, `L_ready=1`.
- Full FIFO, bubble plus new `L_valid` → not accepted that cycle (`L_ready=0`); accepted next cycle; order preserved.
- Reset asserted with 2 entries queued → all outputs zero immediately; after release FIFO empty, no stale write.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the write-back path: result-source select, load funct3
// encodings and the long-latency FIFO entry layout.
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2
  } result_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } llu_entry_t;

endpackage

// File: rtl/load_extend.sv
// Load formatter: picks the byte/halfword addressed by the offset out of the
// aligned memory word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    // Halfword loads ignore off[0]; misalignment is trapped upstream.
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    value_o = word_i;
    case (funct3_i)
      F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  value_o = {24'h0, byte_sel};
      F3_LHU:  value_o = {16'h0, half_sel};
      default: value_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port driver: pipeline result has priority, long-latency
// results queue in a small FIFO and drain into idle write slots.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_valid,
  input  logic        W_gpr_wen_in,
  input  logic [4:0]  W_rd_addr_in,
  input  logic [1:0]  W_result_src,
  input  logic [31:0] W_alu_result,
  input  logic [31:0] W_mem_rdata,
  input  logic [31:0] W_pc_plus4,
  input  logic [2:0]  W_funct3,
  input  logic        L_valid,
  output logic        L_ready,
  input  logic [4:0]  L_rd_addr,
  input  logic [31:0] L_data,
  output logic [4:0]  W_rd_addr,
  output logic [31:0] W_rd,
  output logic        W_gpr_wen,
  output logic [31:0] pend_mask,
  output logic        W_stall_req
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  llu_entry_t [FIFO_DEPTH-1:0] mem_q;
  logic [FIFO_DEPTH-1:0]       vld_q, vld_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic [AW-1:0]               age_q, age_d;

  logic        pw, fifo_empty, push, pop;
  logic [31:0] load_val, pipe_val;
  llu_entry_t  head;

  load_extend u_load_extend (
    .funct3_i (W_funct3),
    .off_i    (W_alu_result[1:0]),
    .word_i   (W_mem_rdata),
    .value_o  (load_val)
  );

  always_comb begin
    pipe_val = W_alu_result;
    case (result_src_t'(W_result_src))
      RES_LOAD: pipe_val = load_val;
      RES_PC4:  pipe_val = W_pc_plus4;
      default:  pipe_val = W_alu_result;
    endcase
  end

  assign pw         = W_valid & W_gpr_wen_in & (W_rd_addr_in != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  // L_ready looks only at registered occupancy, so no W input reaches it.
  assign L_ready    = reset & (count_q < CW'(FIFO_DEPTH));
  assign push       = L_valid & L_ready & (L_rd_addr != 5'd0);
  assign pop        = reset & ~pw & ~fifo_empty;

  always_comb begin
    W_gpr_wen = 1'b0;
    W_rd_addr = 5'd0;
    W_rd      = 32'h0;
    if (reset) begin
      if (pw) begin
        W_gpr_wen = 1'b1;
        W_rd_addr = W_rd_addr_in;
        W_rd      = pipe_val;
      end else if (!fifo_empty) begin
        W_gpr_wen = 1'b1;
        W_rd_addr = head.rd;
        W_rd      = head.data;
      end
    end
  end

  always_comb begin
    pend_mask = 32'h0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (vld_q[i]) pend_mask = pend_mask | (32'h1 << mem_q[i].rd);
  end

  assign W_stall_req = (age_q == AW'(STARVE_LIMIT));

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    vld_d    = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    if (pop || fifo_empty)           age_d = '0;
    else if (W_stall_req)            age_d = age_q;
    else                             age_d = age_q + AW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
    end
  end

  // Payload storage needs no reset: only slots flagged in vld_q are observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: L_rd_addr, data: L_data};
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed check of writeback_unit against a queue-based model.
module tb_writeback_unit;
  localparam int D  = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        W_valid, W_gpr_wen_in, L_valid, L_ready, W_gpr_wen, W_stall_req;
  logic [4:0]  W_rd_addr_in, L_rd_addr, W_rd_addr;
  logic [1:0]  W_result_src;
  logic [31:0] W_alu_result, W_mem_rdata, W_pc_plus4, L_data, W_rd, pend_mask;
  logic [2:0]  W_funct3;

  writeback_unit #(.FIFO_DEPTH(D), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .W_valid(W_valid), .W_gpr_wen_in(W_gpr_wen_in),
    .W_rd_addr_in(W_rd_addr_in), .W_result_src(W_result_src),
    .W_alu_result(W_alu_result), .W_mem_rdata(W_mem_rdata),
    .W_pc_plus4(W_pc_plus4), .W_funct3(W_funct3), .L_valid(L_valid),
    .L_ready(L_ready), .L_rd_addr(L_rd_addr), .L_data(L_data),
    .W_rd_addr(W_rd_addr), .W_rd(W_rd), .W_gpr_wen(W_gpr_wen),
    .pend_mask(pend_mask), .W_stall_req(W_stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   age = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic wen, input logic [4:0] rd,
                       input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [2:0] f3,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    W_valid = wv; W_gpr_wen_in = wen; W_rd_addr_in = rd; W_result_src = src;
    W_alu_result = alu; W_mem_rdata = mem; W_pc_plus4 = alu + 32'd4;
    W_funct3 = f3; L_valid = lv; L_rd_addr = lrd; L_data = ld;
  endtask

  task automatic bubble(input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd2, lv, lrd, ld);
  endtask

  task automatic pipe(input logic [4:0] rd, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ld);
    drive(1'b1, 1'b1, rd, 2'd0, 32'h1000 + rd, 32'h0, 3'd2, lv, lrd, ld);
  endtask

  // Called once per cycle with inputs already applied (edge+1): compares the
  // DUT against the model mid-cycle, then advances the model across the edge.
  task automatic cycle();
    logic        pw, ewen, pop, push;
    logic [4:0]  eaddr;
    logic [31:0] edata, emask, res;
    int          nage;
    #3;
    if (!reset) begin
      q.delete();
      age = 0;
      chk("rst_wen", {31'h0, W_gpr_wen}, 32'h0);
      chk("rst_lready", {31'h0, L_ready}, 32'h0);
      chk("rst_mask", pend_mask, 32'h0);
      chk("rst_stall", {31'h0, W_stall_req}, 32'h0);
      @(posedge clk);
      #1;
      return;
    end
    pw = W_valid && W_gpr_wen_in && (W_rd_addr_in != 5'd0);
    case (W_result_src)
      2'd1:    res = ref_load(W_funct3, W_alu_result[1:0], W_mem_rdata);
      2'd2:    res = W_pc_plus4;
      default: res = W_alu_result;
    endcase
    ewen = 1'b0; eaddr = 5'd0; edata = 32'h0;
    if (pw) begin
      ewen = 1'b1; eaddr = W_rd_addr_in; edata = res;
    end else if (q.size() > 0) begin
      ewen = 1'b1; eaddr = q[0].rd; edata = q[0].d;
    end
    emask = 32'h0;
    foreach (q[i]) emask[q[i].rd] = 1'b1;
    chk("wen", {31'h0, W_gpr_wen}, {31'h0, ewen});
    if (ewen) begin
      chk("waddr", {27'h0, W_rd_addr}, {27'h0, eaddr});
      chk("wdata", W_rd, edata);
    end
    chk("lready", {31'h0, L_ready}, {31'h0, (q.size() < D)});
    chk("pend_mask", pend_mask, emask);
    chk("stall", {31'h0, W_stall_req}, {31'h0, (age == SL)});
    pop  = !pw && q.size() > 0;
    push = L_valid && (q.size() < D) && (L_rd_addr != 5'd0);
    nage = (pop || q.size() == 0) ? 0 : ((age < SL) ? age + 1 : SL);
    @(posedge clk);
    #1;
    if (reset) begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{rd: L_rd_addr, d: L_data});
      age = nage;
    end
  endtask

  initial begin
    reset = 1'b0;
    bubble(1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    cycle();
    chk("rst_addr", {27'h0, W_rd_addr}, 32'h0);
    chk("rst_data", W_rd, 32'h0);
    cycle();
    reset = 1'b1;
    #1 chk("lit_lready_after_release", {31'h0, L_ready}, 32'h1);
    cycle();

    // LB off=3 / LHU off=2 pin the load model
    drive(1'b1, 1'b1, 5'd5, 2'd1, 32'h0000_0103, 32'h80FF_1234, 3'd0, 1'b0, 5'd0, 32'h0);
    #1 chk("lit_lb", W_rd, 32'hFFFF_FF80);
    chk("lit_lb_addr", {27'h0, W_rd_addr}, 32'd5);
    chk("lit_lb_wen", {31'h0, W_gpr_wen}, 32'h1);
    cycle();
    drive(1'b1, 1'b1, 5'd5, 2'd1, 32'h0000_0102, 32'h80FF_1234, 3'd5, 1'b0, 5'd0, 32'h0);
    #1 chk("lit_lhu", W_rd, 32'h0000_80FF);
    cycle();

    // x0 targets: pipeline write suppressed, L result dropped
    pipe(5'd0, 1'b0, 5'd0, 32'h0);
    #1 chk("lit_x0_wen", {31'h0, W_gpr_wen}, 32'h0);
    cycle();
    bubble(1'b1, 5'd0, 32'h1234_5678);
    #1 chk("lit_x0_lready", {31'h0, L_ready}, 32'h1);
    cycle();
    bubble(1'b0, 5'd0, 32'h0);
    #1 chk("lit_x0_mask", pend_mask, 32'h0);
    chk("lit_x0_nowrite", {31'h0, W_gpr_wen}, 32'h0);
    cycle();

    // x7 queued behind two busy pipeline cycles
    pipe(5'd3, 1'b1, 5'd7, 32'hDEAD_BEEF);
    cycle();
    pipe(5'd4, 1'b0, 5'd0, 32'h0);
    #1 chk("lit_x7_pend", pend_mask, 32'h0000_0080);
    cycle();
    bubble(1'b0, 5'd0, 32'h0);
    #1 chk("lit_x7_addr", {27'h0, W_rd_addr}, 32'd7);
    chk("lit_x7_data", W_rd, 32'hDEAD_BEEF);
    cycle();
    #1 chk("lit_x7_clear", pend_mask, 32'h0);
    cycle();

    // starvation: fill under continuous pw, then wait for the stall request
    pipe(5'd1, 1'b1, 5'd9, 32'hAAAA_0009);
    cycle();
    pipe(5'd2, 1'b1, 5'd10, 32'hAAAA_000A);
    cycle();
    pipe(5'd3, 1'b0, 5'd0, 32'h0);
    #1 chk("lit_full_lready", {31'h0, L_ready}, 32'h0);
    cycle();
    cycle();
    cycle();
    bubble(1'b0, 5'd0, 32'h0);
    #1 chk("lit_stall", {31'h0, W_stall_req}, 32'h1);
    chk("lit_starve_addr", {27'h0, W_rd_addr}, 32'd9);
    cycle();
    pipe(5'd4, 1'b1, 5'd11, 32'hAAAA_000B);
    #1 chk("lit_stall_clr", {31'h0, W_stall_req}, 32'h0);
    chk("lit_lready_back", {31'h0, L_ready}, 32'h1);
    cycle();
    bubble(1'b1, 5'd12, 32'hAAAA_000C);
    #1 chk("lit_full_bubble_lready", {31'h0, L_ready}, 32'h0);
    cycle();
    pipe(5'd5, 1'b1, 5'd12, 32'hAAAA_000C);
    #1 chk("lit_retry_lready", {31'h0, L_ready}, 32'h1);
    cycle();
    bubble(1'b0, 5'd0, 32'h0);
    #1 chk("lit_order_11", {27'h0, W_rd_addr}, 32'd11);
    cycle();
    #1 chk("lit_order_12", W_rd, 32'hAAAA_000C);
    cycle();

    // reset with two entries queued
    pipe(5'd6, 1'b1, 5'd13, 32'h1);
    cycle();
    pipe(5'd6, 1'b1, 5'd14, 32'h2);
    cycle();
    pipe(5'd6, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    #1 chk("lit_rst_wen", {31'h0, W_gpr_wen}, 32'h0);
    chk("lit_rst_mask", pend_mask, 32'h0);
    chk("lit_rst_data", W_rd, 32'h0);
    cycle();
    reset = 1'b1;
    bubble(1'b0, 5'd0, 32'h0);
    #1 chk("lit_no_stale", {31'h0, W_gpr_wen}, 32'h0);
    cycle();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic wv;
      wv = ($urandom_range(0, 99) < 70) && !(age == SL && $urandom_range(0, 1) == 1);
      drive(wv, $urandom_range(0, 7) != 0,
            ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom),
            2'($urandom_range(0, 2)), $urandom, $urandom, 3'($urandom),
            $urandom_range(0, 99) < 40,
            ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom), $urandom);
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      cycle();
      reset = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
